// File: rtl/mult_issue_sched.sv
// Issue scheduler for a shared multi-cycle multiplier: round-robin grant among
// reservation-station entries, occupancy countdown, then a CDB broadcast handshake.
module mult_issue_sched #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 6,
    parameter int LAT     = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     squash,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     fu_start,
    output logic                     busy,
    output logic                     cdb_req,
    output logic [TAG_W-1:0]         cdb_tag,
    input  logic                     cdb_ack
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   ptr, ptr_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [TAG_W-1:0]   tag_q, tag_nxt;
    logic [PTR_W-1:0]   pick;
    logic [NUM_REQ-1:0] pick_oh;
    logic [TAG_W-1:0]   pick_tag;

    // First set request at or after ptr+1, wrapping; the previous winner ends up last.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [PTR_W-1:0]   p);
        logic             found;
        int               idx;
        logic [PTR_W-1:0] pi;
        rr_pick = p;
        found   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(p) + k) % NUM_REQ;
            pi  = PTR_W'(idx);
            if (!found && r[pi]) begin
                rr_pick = pi;
                found   = 1'b1;
            end
        end
    endfunction

    always_comb begin
        pick     = rr_pick(req, ptr);
        pick_oh  = '0;
        pick_tag = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == pick) begin
                pick_oh[i] = 1'b1;
                pick_tag   = req_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        tag_nxt   = tag_q;
        gnt       = '0;
        cdb_req   = reset && en && (state == DONE);
        if (squash) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt       = pick_oh;
                        ptr_nxt   = pick;
                        tag_nxt   = pick_tag;
                        cnt_nxt   = CNT_LOAD;
                        state_nxt = BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
                    else           state_nxt = DONE;
                end
                DONE: begin
                    if (cdb_ack) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
        // Reset is asynchronous, so the combinational grant must drop with it.
        if (!reset) gnt = '0;
    end

    assign fu_start = |gnt;
    assign busy     = (state != IDLE);
    assign cdb_tag  = tag_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ptr   <= PTR_RST;
            cnt   <= '0;
            tag_q <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            tag_q <= tag_nxt;
        end
    end

endmodule

// File: tb/tb_mult_issue_sched.sv
// Directed bench for mult_issue_sched with a phase-level reference model checked every cycle.
module tb_mult_issue_sched;

    localparam int N  = 4;
    localparam int TW = 6;
    localparam int L  = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            en = 1'b1;
    logic            squash = 1'b0;
    logic            cdb_ack = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*TW-1:0] req_tag = '0;
    logic [N-1:0]    gnt;
    logic            fu_start, busy, cdb_req;
    logic [TW-1:0]   cdb_tag;

    mult_issue_sched #(.NUM_REQ(N), .TAG_W(TW), .LAT(L)) dut (
        .clock(clock), .reset(reset), .en(en), .squash(squash),
        .req(req), .req_tag(req_tag), .gnt(gnt), .fu_start(fu_start),
        .busy(busy), .cdb_req(cdb_req), .cdb_tag(cdb_tag), .cdb_ack(cdb_ack)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 multiplier occupied, 2 waiting for the CDB.
    int            m_st   = 0;
    int            m_left = 0;
    int            m_ptr  = N - 1;
    logic [TW-1:0] m_tag  = '0;

    function automatic int rr(input logic [N-1:0] r, input int p);
        for (int k = 1; k <= N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    always @(posedge clock or negedge reset) begin
        int g;
        if (!reset) begin
            m_st = 0; m_left = 0; m_ptr = N - 1; m_tag = '0;
        end else if (squash) begin
            m_st = 0; m_left = 0;
        end else if (en) begin
            if (m_st == 0) begin
                g = rr(req, m_ptr);
                if (g >= 0) begin
                    m_ptr = g; m_tag = req_tag[g*TW +: TW]; m_left = L; m_st = 1;
                end
            end else if (m_st == 1) begin
                m_left--;
                if (m_left == 0) m_st = 2;
            end else if (cdb_ack) begin
                m_st = 0;
            end
        end
    end

    always @(negedge clock) begin
        logic [N-1:0] exp_g;
        int g;
        exp_g = '0;
        if (reset && m_st == 0 && en && !squash) begin
            g = rr(req, m_ptr);
            if (g >= 0) exp_g[g] = 1'b1;
        end
        chk("gnt", 32'(gnt), 32'(exp_g));
        chk("fu_start", 32'(fu_start), 32'(|exp_g));
        chk("busy", 32'(busy), 32'(reset && m_st != 0));
        chk("cdb_req", 32'(cdb_req), 32'(reset && en && m_st == 2));
        chk("cdb_tag", 32'(cdb_tag), reset ? 32'(m_tag) : 32'd0);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        tick();
        reset = 1'b1;
    endtask

    task automatic set_tags(input int t0, input int t1, input int t2, input int t3);
        req_tag = {TW'(t3), TW'(t2), TW'(t1), TW'(t0)};
    endtask

    initial begin
        set_tags(5, 1, 9, 3);
        req = 4'b0101;
        #1 reset = 1'b0;
        #2;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cdb_req", 32'(cdb_req), 32'd0);
        chk("rst_cdb_tag", 32'(cdb_tag), 32'd0);
        tick();
        reset = 1'b1;

        // Back-to-back issue of entries 0 and 2 with the ack tied high.
        for (int c = 0; c < 12; c++) begin
            if (c == 1) req = 4'b0100;
            if (c == 7) req = 4'b0000;
            #3;
            if (c == 0) chk("a_gnt0", 32'(gnt), 32'd1);
            if (c >= 1 && c <= 4) begin
                chk("a_busy", 32'(busy), 32'd1);
                chk("a_nocdb", 32'(cdb_req), 32'd0);
            end
            if (c == 5) begin
                chk("a_cdb5", 32'(cdb_req), 32'd1);
                chk("a_tag5", 32'(cdb_tag), 32'd5);
            end
            if (c == 6) chk("a_gnt2", 32'(gnt), 32'd4);
            if (c == 11) begin
                chk("a_cdb11", 32'(cdb_req), 32'd1);
                chk("a_tag9", 32'(cdb_tag), 32'd9);
            end
            tick();
        end

        // All requests held: fair rotation 0,1,2,3,0.
        pulse_reset();
        req = 4'b1111;
        for (int c = 0; c < 30; c++) begin
            #3;
            if (c % 6 == 0) chk("b_rr_order", 32'(gnt), 32'(1) << ((c / 6) % 4));
            tick();
        end
        req = 4'b0000;

        // Ack withheld for three DONE cycles.
        set_tags(42, 1, 9, 3);
        cdb_ack = 1'b0;
        req = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            if (c == 1) req = 4'b0000;
            if (c == 8) cdb_ack = 1'b1;
            #3;
            if (c == 0) chk("c_gnt", 32'(gnt), 32'd1);
            if (c >= 5 && c <= 8) begin
                chk("c_cdb_hold", 32'(cdb_req), 32'd1);
                chk("c_tag_hold", 32'(cdb_tag), 32'd42);
            end
            if (c == 9) chk("c_idle", 32'(busy), 32'd0);
            tick();
        end

        // Squash on the second BUSY cycle, then round-robin resumes from entry 1.
        req = 4'b0010;
        for (int c = 0; c < 10; c++) begin
            if (c == 1) req = 4'b0000;
            if (c == 2) begin squash = 1'b1; req = 4'b1111; end
            if (c == 3) squash = 1'b0;
            if (c == 4) req = 4'b0000;
            #3;
            if (c == 0) chk("d_gnt1", 32'(gnt), 32'd2);
            if (c == 2) chk("d_sq_gnt", 32'(gnt), 32'd0);
            if (c == 3) begin
                chk("d_sq_busy", 32'(busy), 32'd0);
                chk("d_next_rr", 32'(gnt), 32'd4);
            end
            if (c == 8) chk("d_tag", 32'(cdb_tag), 32'd9);
            tick();
        end

        // Enable stalls in BUSY and in DONE.
        req = 4'b1000;
        for (int c = 0; c < 11; c++) begin
            if (c == 1) req = 4'b0000;
            if (c == 2) en = 1'b0;
            if (c == 4) en = 1'b1;
            if (c == 7) en = 1'b0;
            if (c == 8) begin en = 1'b1; cdb_ack = 1'b0; end
            if (c == 9) cdb_ack = 1'b1;
            #3;
            if (c == 0) chk("e_gnt3", 32'(gnt), 32'd8);
            if (c >= 1 && c <= 9) chk("e_busy", 32'(busy), 32'd1);
            if (c >= 1 && c <= 7) chk("e_nocdb", 32'(cdb_req), 32'd0);
            if (c == 8 || c == 9) chk("e_cdb", 32'(cdb_req), 32'd1);
            if (c == 10) chk("e_idle", 32'(busy), 32'd0);
            tick();
        end

        // Asynchronous reset pulse between edges while in DONE.
        cdb_ack = 1'b0;
        req = 4'b0001;
        for (int c = 0; c < 7; c++) begin
            if (c == 1) req = 4'b0000;
            if (c == 0) begin
                #3;
                chk("f_gnt0", 32'(gnt), 32'd1);
            end else if (c == 5) begin
                req = 4'b0010;
                #1;
                chk("f_cdb_pre", 32'(cdb_req), 32'd1);
                reset = 1'b0;
                #1;
                chk("f_rst_gnt", 32'(gnt), 32'd0);
                chk("f_rst_fu", 32'(fu_start), 32'd0);
                chk("f_rst_busy", 32'(busy), 32'd0);
                chk("f_rst_cdb", 32'(cdb_req), 32'd0);
                chk("f_rst_tag", 32'(cdb_tag), 32'd0);
                req = 4'b0000;
                #1 reset = 1'b1;
            end else if (c == 6) begin
                #3;
                chk("f_post_busy", 32'(busy), 32'd0);
                chk("f_post_cdb", 32'(cdb_req), 32'd0);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
